// File: rtl/register_bank_valid.sv
// register_bank_valid: bank of valid-tagged registers with load/increment/invalidate,
// async clear/preset, combinational tri-stateable read port.
module register_bank_valid #(
  parameter int NrOfBits    = 8,
  parameter int NrOfRegs    = 4,
  parameter int AddrBits    = 2,
  parameter int ActiveLevel = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Pre,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic [1:0]          Op,
  input  logic [AddrBits-1:0] WAddr,
  input  logic [NrOfBits-1:0] D,
  input  logic [AddrBits-1:0] RAddr,
  input  logic                cs,
  output logic [NrOfBits-1:0] Q,
  output logic                QValid,
  output logic                AllValid,
  output logic                Overflow
);

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_INV  = 2'b11
  } op_e;

  op_e                op;
  logic               upd_clk;
  logic               upd_en;
  logic [NrOfBits-1:0] data_q [NrOfRegs];
  logic [NrOfRegs-1:0] valid_q;
  logic               overflow_q;
  logic [NrOfBits:0]  inc_sum [NrOfRegs];
  logic [NrOfBits-1:0] rd_data;
  logic               rd_valid;

  assign op      = op_e'(Op);
  assign upd_en  = ClockEnable & Tick;
  // Falling-edge variant simply runs the same flops off the inverted clock
  assign upd_clk = (ActiveLevel != 0) ? Clock : ~Clock;

  always_comb begin
    for (int i = 0; i < NrOfRegs; i++) begin
      inc_sum[i] = {1'b0, data_q[i]} + (NrOfBits+1)'(1);
    end
  end

  always_ff @(posedge upd_clk or posedge Reset or posedge Pre) begin
    if (Reset) begin
      for (int i = 0; i < NrOfRegs; i++) begin
        data_q[i] <= '0;
      end
      valid_q    <= '0;
      overflow_q <= 1'b0;
    end else if (Pre) begin
      for (int i = 0; i < NrOfRegs; i++) begin
        data_q[i] <= '1;
      end
      valid_q    <= '1;
      overflow_q <= 1'b0;
    end else if (upd_en) begin
      // Out-of-range WAddr matches no entry, so the update vanishes
      for (int i = 0; i < NrOfRegs; i++) begin
        if (WAddr == AddrBits'(i)) begin
          unique case (op)
            OP_LOAD: begin
              data_q[i]  <= D;
              valid_q[i] <= 1'b1;
            end
            OP_INC: begin
              if (valid_q[i]) begin
                data_q[i] <= inc_sum[i][NrOfBits-1:0];
                if (inc_sum[i][NrOfBits]) begin
                  overflow_q <= 1'b1;
                end
              end
            end
            OP_INV: begin
              valid_q[i] <= 1'b0;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_valid = 1'b0;
    for (int i = 0; i < NrOfRegs; i++) begin
      if (RAddr == AddrBits'(i)) begin
        rd_data  = data_q[i];
        rd_valid = valid_q[i];
      end
    end
  end

  assign Q        = cs ? 'z : rd_data;
  assign QValid   = cs ? 1'bz : rd_valid;
  assign AllValid = &valid_q;
  assign Overflow = overflow_q;

endmodule

// File: doc/register_bank_valid.md
Name: register_bank_valid

Overview:
- Parametrised successor to the single tick-gated flip-flop register.
- Bank of NrOfRegs registers, each NrOfBits wide, with one write/update port and one combinational read port.
- Each entry has a valid bit. Per-entry ops: load, increment, invalidate.
- Async clear and async preset; tri-stateable read output for shared-bus use in the memory subsystem.

Parameters:
- NrOfBits, 8, data width per entry (1..32).
- NrOfRegs, 4, number of entries (1..2^AddrBits).
- AddrBits, 2, width of WAddr/RAddr.
- ActiveLevel, 1, 1 = state updates on rising Clock edge; 0 = falling edge.

Ports:
- Clock, in, 1, system clock; active edge set by ActiveLevel.
- Reset, in, 1, asynchronous, active-high; highest priority.
- Pre, in, 1, asynchronous, active-high preset; priority below Reset.
- ClockEnable, in, 1, update qualifier.
- Tick, in, 1, update qualifier; an update happens only when ClockEnable&Tick=1 on the active edge.
- Op, in, 2, 00 hold, 01 load, 10 increment, 11 invalidate.
- WAddr, in, AddrBits, target entry for Op.
- D, in, NrOfBits, load data.
- RAddr, in, AddrBits, read select.
- cs, in, 1, 1 = Q/QValid driven high-Z; 0 = driven.
- Q, out, NrOfBits, data of entry RAddr.
- QValid, out, 1, valid bit of entry RAddr.
- AllValid, out, 1, AND of all NrOfRegs valid bits; never tri-stated.
- Overflow, out, 1, sticky flag: an increment wrapped.

Behaviour:
- Reset=1, asynchronous: all data=0, all valid=0, Overflow=0. Resulting outputs: Q=0, QValid=0, AllValid=0.
- Reset also applies at time zero (initial state identical to reset).
- Pre=1 with Reset=0, asynchronous: all data = all ones, all valid=1, Overflow=0.
- Reset and Pre both high: Reset wins.
- Update condition: active edge AND ClockEnable=1 AND Tick=1 AND Reset=0 AND Pre=0. Otherwise all state holds.
- Op 01 load: entry[WAddr] <= D; valid[WAddr] <= 1.
- Op 10 increment:
  - If valid[WAddr]=1: entry <= entry+1, modulo 2^NrOfBits.
  - If the old value was all ones, the entry wraps to 0 and Overflow <= 1.
  - If valid[WAddr]=0: no change to entry, valid or Overflow.
- Op 11 invalidate: valid[WAddr] <= 0; data retained.
- Op 00: no change.
- Only one entry changes per update. Other entries are untouched.
- Overflow is cleared only by Reset or Pre.
- WAddr >= NrOfRegs (out of range): update ignored entirely, including Overflow.
- Read path:
  - Purely combinational, zero latency.
  - A value written at an edge is visible on Q immediately after that edge.
  - RAddr >= NrOfRegs: Q=0, QValid=0.
  - cs=1: Q and QValid = high-Z regardless of state. cs has no effect on state or on AllValid/Overflow.
- ActiveLevel=0: identical behaviour with all synchronous updates on the falling edge. Async Reset/Pre are unaffected.
- Reset or Pre asserted mid-operation overrides any update sampled at the same instant. On deassertion, updates resume at the next qualifying edge.
- Width rules: increment carry-out is discarded (it only sets Overflow). D is loaded unextended; widths match.

Test Plan:
- Reset sequence: pulse Reset with cs=0, RAddr=0..3 -> Q=0, QValid=0, AllValid=0, Overflow=0 for every address.
- Loads: load 0x12,0x34,0x56,0x78 into entries 0..3 with Tick=1 -> readback matches each value, QValid=1. AllValid goes 1 only after the 4th load.
- Tick gating: load 0xAA to entry 1 with Tick=0, then with ClockEnable=0 -> entry 1 stays 0x34. Then Tick=1, ClockEnable=1 -> entry 1 = 0xAA.
- Increment and wrap:
  - Load 0xFE into entry 2, increment twice -> 0xFF then 0x00, Overflow=1 and sticky through further loads.
  - Invalidate entry 2, then increment -> value stays 0x00 and QValid=0.
- Preset and priority:
  - Assert Pre mid-run -> all entries 0xFF, valid=1, Overflow=0.
  - Assert Reset and Pre together -> all 0. Release Pre first, then Reset -> state stays 0.
- Tristate and range:
  - cs=1 -> Q=8'hzz, QValid=z; AllValid still driven.
  - With NrOfRegs=3 and WAddr=3, a load is ignored. RAddr=3 -> Q=0, QValid=0.
  - Rerun the Loads and Increment-and-wrap scenarios with ActiveLevel=0 and check that updates occur on the falling edges.
